// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target.
// Contents: FSM state encoding and the ACK/NACK bus levels.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one open-drain bus line.
// A new level is accepted only after it has been stable for FILTER_LEN
// clk at the synchroniser output; pad edge to filtered edge is
// 2+FILTER_LEN clk.
// Ports:
//   clk    - peripheral clock
//   nreset - asynchronous active-low reset (line reads as released/1)
//   raw    - raw pad level
//   filt   - synchronised, glitch-filtered level
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic nreset,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync <= 2'b11;
      cnt  <= 3'd0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= 3'd0;
      end else if (cnt == 3'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address and 8-bit register pointer.
// Write: S addr+W ptr data... P  -> reg_we per data byte, pointer auto-increments.
// Read:  S addr+R data... P (usually after S addr+W ptr Sr) -> reg_rd_req per byte.
// Optional feature macro: I2C_TARGET_STRETCH_EN (clock stretching on read
// fetches, waits for reg_rd_ack). Undefined: scl_pull tied 0, reg_rd_ack
// ignored, reg_rdata must be valid 1 clk after reg_rd_req.
// Ports:
//   clk, nreset           - clock, asynchronous active-low reset
//   scl_in, sda_in        - raw pad levels
//   sda_pull, scl_pull    - 1 = drive line low (open drain)
//   reg_addr, reg_wdata   - register pointer and write data
//   reg_we                - one-cycle write strobe
//   reg_rdata, reg_rd_ack - read data and its valid flag
//   reg_rd_req            - one-cycle read request
//   busy                  - addressed START until next STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull,
  output logic       scl_pull,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_rd_req,
  input  logic       reg_rd_ack,
  output logic       busy
);

  state_t     state, state_nx;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       mack, tx_bit, fetch, latch_now, fetch_go;
  logic       byte_done, addr_match, shift_state;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .nreset(nreset), .raw(scl_in), .filt(scl_f));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .nreset(nreset), .raw(sda_in), .filt(sda_f));

  assign scl_rise    = scl_f & ~scl_q;
  assign scl_fall    = ~scl_f & scl_q;
  assign start_ev    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev     = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_done   = (bit_cnt == 4'd8);
  assign addr_match  = (shift[7:1] == TARGET_ADDR);
  assign shift_state = (state inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA});
  // Every read byte is fetched at the SCL fall that begins it.
  assign fetch_go    = scl_fall && (state_nx == ST_RDATA) && (state != ST_RDATA);

`ifdef I2C_TARGET_STRETCH_EN
  logic rel;
  assign latch_now = fetch & reg_rd_ack;
  // SCL is held one extra clk after the latch so SDA is set up first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rel <= 1'b0;
    else         rel <= latch_now & ~start_ev & ~stop_ev;
  end
  assign scl_pull = fetch | rel;
`else
  logic unused_rd_ack;
  assign unused_rd_ack = reg_rd_ack;
  // reg_rdata is valid the clk after the request pulse.
  assign latch_now = fetch & ~reg_rd_req;
  assign scl_pull  = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Byte phases advance on SCL fall so SDA only ever changes with SCL low.
  always_comb begin
    state_nx = state;
    if (start_ev) begin
      state_nx = ST_ADDR;
    end else if (stop_ev) begin
      state_nx = ST_IDLE;
    end else if (scl_fall) begin
      case (state)
        ST_ADDR:      if (byte_done) state_nx = addr_match ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:  state_nx = shift[0] ? ST_RDATA : ST_PTR;
        ST_PTR:       if (byte_done) state_nx = ST_PTR_ACK;
        ST_PTR_ACK:   state_nx = ST_WDATA;
        ST_WDATA:     if (byte_done) state_nx = ST_WDATA_ACK;
        ST_WDATA_ACK: state_nx = ST_WDATA;
        ST_RDATA:     if (byte_done) state_nx = ST_RDATA_ACK;
        ST_RDATA_ACK: state_nx = (mack == NACK) ? ST_IDLE : ST_RDATA;
        default:      state_nx = state;
      endcase
    end
  end

  always_comb begin
    sda_pull = 1'b0;
    case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_pull = 1'b1;
      ST_RDATA:                              sda_pull = ~fetch & ~tx_bit;
      default:                               sda_pull = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bit_cnt    <= 4'd0;
      shift      <= 8'd0;
      mack       <= NACK;
      tx_bit     <= 1'b1;
      fetch      <= 1'b0;
      reg_addr   <= 8'd0;
      reg_wdata  <= 8'd0;
      reg_we     <= 1'b0;
      reg_rd_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      scl_q      <= scl_f;
      sda_q      <= sda_f;
      reg_we     <= 1'b0;
      reg_rd_req <= 1'b0;
      if (start_ev) begin
        bit_cnt <= 4'd0;
        fetch   <= 1'b0;
      end else if (stop_ev) begin
        bit_cnt <= 4'd0;
        fetch   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (scl_rise) begin
          if (shift_state && !byte_done) begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
            if (state == ST_WDATA && bit_cnt == 4'd7) begin
              reg_we    <= 1'b1;
              reg_wdata <= {shift[6:0], sda_f};
            end
          end
          if (state == ST_RDATA_ACK) begin
            mack <= sda_f;
            if (sda_f == ACK) reg_addr <= reg_addr + 8'd1;
          end
        end
        if (scl_fall) begin
          case (state)
            ST_ADDR:      if (byte_done && addr_match) busy <= 1'b1;
            ST_PTR:       if (byte_done) reg_addr <= shift;
            ST_WDATA_ACK: reg_addr <= reg_addr + 8'd1;
            ST_RDATA:     if (!byte_done) tx_bit <= shift[7];
            default:      ;
          endcase
          if (fetch_go) begin
            fetch      <= 1'b1;
            reg_rd_req <= 1'b1;
          end
        end
        if (state_nx != state) bit_cnt <= 4'd0;
        if (latch_now) begin
          shift  <= reg_rdata;
          tx_bit <= reg_rdata[7];
          fetch  <= 1'b0;
        end
      end
    end
  end

endmodule
